tomasulo_cdb_arb: RTL

//  Common Data Bus arbiter/scheduler; the counterpart of the reservation station's cdb_req/cdb_gnt/sch_r/cdb_r interface.
//  - Grants at most one RS issue per cycle, round-robin.
//  - Reserves the future CDB slot for each grant in the shared schedule vector sch_r.
//  - Registers the single functional-unit result completing each cycle onto cdb_r.
//  - Sits between the K reservation stations/functional units and every CDB snooper (RS entries, ROB, regfile).

---
 rtl/tomasulo_pkg.sv | 32 +++
 rtl/tomasulo_cdb_arb_if.sv | 36 +++
 rtl/tomasulo_rr_arb.sv | 32 +++
 rtl/tomasulo_cdb_arb.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg -- shared types for the Tomasulo datapath slice.
//   SCH_W   : depth of the CDB slot reservation vector
//   sch_t   : slot reservation vector, bit j = CDB slot j cycles ahead
//   tag_t   : result tag broadcast on the CDB
//   word_t  : result data word
//   cdb_t   : registered CDB broadcast {vld, tag, wdata}
//   lat_of  : extracts the 4-bit latency field k from a packed latency vector
package tomasulo_pkg;

  localparam int SCH_W     = 8;
  localparam int TAG_W     = 4;
  localparam int WORD_W    = 32;
  localparam int LAT_W     = 4;
  localparam int MAX_UNITS = 16;

  typedef logic [SCH_W-1:0]  sch_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  // Field k of a packed latency vector; callers zero-extend narrower vectors.
  function automatic int unsigned lat_of(input logic [LAT_W*MAX_UNITS-1:0] vec,
                                         input int unsigned k);
    return {{(32-LAT_W){1'b0}}, vec[k*LAT_W +: LAT_W]};
  endfunction

endpackage

// File: rtl/tomasulo_cdb_arb_if.sv
// tomasulo_cdb_arb_if -- bundle between the CDB arbiter and the K
// reservation-station / functional-unit pairs.
//   cdb_req  : per-RS request (RS has a ready entry and saw its slot free)
//   cdb_gnt  : one-hot-or-zero grant
//   sch_r    : shared slot reservation vector
//   fu_vld   : per-unit completed-result strobe
//   fu_tag   : per-unit result tag
//   fu_wdata : per-unit result data
//   cdb_r    : registered CDB broadcast
//   err_r    : sticky protocol error
// master = arbiter side, slave = RS/FU side.
interface tomasulo_cdb_arb_if #(
  parameter int K = 2
);
  import tomasulo_pkg::*;

  logic  [K-1:0] cdb_req;
  logic  [K-1:0] cdb_gnt;
  sch_t          sch_r;
  logic  [K-1:0] fu_vld;
  tag_t  [K-1:0] fu_tag;
  word_t [K-1:0] fu_wdata;
  cdb_t          cdb_r;
  logic          err_r;

  modport master (
    input  cdb_req, fu_vld, fu_tag, fu_wdata,
    output cdb_gnt, sch_r, cdb_r, err_r
  );

  modport slave (
    output cdb_req, fu_vld, fu_tag, fu_wdata,
    input  cdb_gnt, sch_r, cdb_r, err_r
  );

endinterface

// File: rtl/tomasulo_rr_arb.sv
// tomasulo_rr_arb -- purely combinational round-robin picker.
//   req : request vector
//   ptr : index that has highest priority this cycle
//   gnt : one-hot (or zero when req==0) grant
// The pointer register lives in the parent.
module tomasulo_rr_arb #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int   idx;
  logic found;

  // Scan N positions starting at ptr, wrapping; first requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// tomasulo_cdb_arb -- Common Data Bus arbiter / scheduler.
// Grants at most one RS issue per cycle (round-robin), reserves the CDB
// slot L_k cycles ahead in sch_r, and registers the single result that
// completes each cycle onto cdb_r.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : tomasulo_cdb_arb_if.master (cdb_req/cdb_gnt/sch_r/fu_*/cdb_r/err_r)
// Parameters:
//   K           : number of RS/FU pairs
//   LATENCY_VEC : packed K x 4b issue-to-result latencies, field k = L_k,
//                 1 <= L_k <= SCH_W-1
// Build option:
//   TOMASULO_CDB_ARB_ERR_EN : enables sticky err_r and SVA checkers; when
//                             undefined err_r is tied low.
module tomasulo_cdb_arb
  import tomasulo_pkg::*;
#(
  parameter int               K           = 2,
  parameter logic [LAT_W*K-1:0] LATENCY_VEC = {4'd2, 4'd4}
) (
  input  logic                clk,
  input  logic                rst,
  tomasulo_cdb_arb_if.master  bus
);

  localparam int PTR_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [LAT_W*MAX_UNITS-1:0] LAT_VEC_EXT =
    (LAT_W*MAX_UNITS)'(LATENCY_VEC);

  sch_t             sch_r;
  sch_t             sch_w;
  sch_t             claim [K];
  logic [K-1:0]     elig;
  logic [K-1:0]     gnt;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] rr_ptr_w;
  logic [PTR_W-1:0] gnt_idx;

  logic             one_vld;
  tag_t             sel_tag;
  word_t            sel_wdata;
  logic             cdb_vld_r;
  tag_t             cdb_tag_r;
  word_t            cdb_wdata_r;

  // Issue stage: eligibility re-checks the target slot itself rather than
  // trusting the RS-side gating, so a stale request can never collide.
  for (genvar k = 0; k < K; k++) begin : g_unit
    localparam int unsigned L = lat_of(LAT_VEC_EXT, k);
    assign elig[k]  = bus.cdb_req[k] & ~sch_r[L];
    assign claim[k] = gnt[k] ? (sch_t'(1) << (L - 1)) : '0;
  end

  tomasulo_rr_arb #(.N(K)) u_rr_arb (
    .req (elig),
    .ptr (rr_ptr_r),
    .gnt (gnt)
  );

  assign bus.cdb_gnt = gnt;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < K; k++) begin
      if (gnt[k]) gnt_idx = PTR_W'(k);
    end
  end

  assign rr_ptr_w = (int'(gnt_idx) == K - 1) ? '0 : gnt_idx + 1'b1;

  // The vector ages by one slot every cycle; a grant lands at bit L_k-1 so
  // that it reaches bit 0 exactly L_k cycles after the grant.
  always_comb begin
    sch_w = sch_r >> 1;
    for (int k = 0; k < K; k++) begin
      sch_w = sch_w | claim[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sch_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      sch_r <= sch_w;
      if (|gnt) rr_ptr_r <= rr_ptr_w;
    end
  end

  assign bus.sch_r = sch_r;

  // Result stage: only a single completing unit is broadcast; zero or
  // several strobes leave the bus idle for this slot.
  assign one_vld = $onehot(bus.fu_vld);

  always_comb begin
    sel_tag   = '0;
    sel_wdata = '0;
    for (int k = 0; k < K; k++) begin
      if (bus.fu_vld[k]) begin
        sel_tag   = bus.fu_tag[k];
        sel_wdata = bus.fu_wdata[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cdb_vld_r <= 1'b0;
    else     cdb_vld_r <= one_vld;
  end

  // Payload is don't-care while vld is low, so it carries no reset.
  always_ff @(posedge clk) begin
    if (one_vld) begin
      cdb_tag_r   <= sel_tag;
      cdb_wdata_r <= sel_wdata;
    end
  end

  assign bus.cdb_r = {cdb_vld_r, cdb_tag_r, cdb_wdata_r};

`ifdef TOMASULO_CDB_ARB_ERR_EN
  logic multi_vld;
  logic err_evt;
  logic err_q;

  // Error: several units completing at once, or any completion landing in
  // a slot nobody reserved.
  assign multi_vld = (|bus.fu_vld) & ~one_vld;
  assign err_evt   = multi_vld | ((|bus.fu_vld) & ~sch_r[0]);

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_evt) err_q <= 1'b1;
  end

  assign bus.err_r = err_q;

  a_no_proto_err: assert property (@(posedge clk) disable iff (rst) !err_evt)
    else $error("tomasulo_cdb_arb: CDB protocol error event fu_vld=%b sch0=%b",
                bus.fu_vld, sch_r[0]);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("tomasulo_cdb_arb: grant not one-hot-or-zero %b", gnt);
`else
  assign bus.err_r = 1'b0;
`endif

endmodule
